// File: rtl/led_color_sel.sv
// Push-button color selector: debounced button, short press flips the color,
// long press toggles automatic red/green alternation with period 2*SWAP_CYC.
module led_color_sel #(
  parameter int unsigned IN_HZ        = 50_000_000,
  parameter int unsigned DEBOUNCE_CYC = IN_HZ / 100,
  parameter int unsigned LONG_CYC     = IN_HZ,
  parameter int unsigned SWAP_CYC     = IN_HZ * 5
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic dsp_Hex,
  output logic auto_mode,
  output logic press_short,
  output logic press_long
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int unsigned HOLD_W = $clog2(LONG_CYC + 1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [31:0]       SWAP_LAST = 32'(SWAP_CYC - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HELD = 2'd1;
  localparam logic [1:0] S_LONG = 2'd2;

  logic              sync1;
  logic              sync2;
  logic              sync_pressed;
  logic              btn_db;
  logic [DB_W-1:0]   db_cnt;
  logic              db_accept;
  logic              db_rise;
  logic              db_fall;

  logic [1:0]        state;
  logic [1:0]        state_d;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_d;
  logic              short_evt;
  logic              long_evt;

  logic [31:0]       swap_cnt;
  logic              swap_term;

  assign sync_pressed = ~sync2;

  // The debounced level flips on the DEBOUNCE_CYC-th consecutive disagreeing sample.
  assign db_accept = (sync_pressed != btn_db) && (db_cnt == DB_LAST);
  assign db_rise   = db_accept & sync_pressed;
  assign db_fall   = db_accept & ~sync_pressed;

  // Two-flop synchronizer; resets to the released (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Debounce: count consecutive disagreeing cycles, any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_db <= 1'b0;
      db_cnt <= '0;
    end else if (sync_pressed == btn_db) begin
      db_cnt <= '0;
    end else if (db_accept) begin
      btn_db <= sync_pressed;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Press classification; the FSM reacts on the same edge the debounced level changes.
  always_comb begin
    state_d    = state;
    hold_cnt_d = hold_cnt;
    short_evt  = 1'b0;
    long_evt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (db_rise) begin
          state_d    = S_HELD;
          hold_cnt_d = '0;
        end
      end
      S_HELD: begin
        // A release on the terminal cycle still counts as a short press, so the FSM
        // never sits in LONG after the level has already dropped.
        if (db_fall) begin
          state_d   = S_IDLE;
          short_evt = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_d  = S_LONG;
          long_evt = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt + 1'b1;
        end
      end
      S_LONG: begin
        // hold_cnt is left at its terminal value until the next press.
        if (db_fall) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state, hold counter and the one-cycle press pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      press_short <= 1'b0;
      press_long  <= 1'b0;
    end else begin
      state       <= state_d;
      hold_cnt    <= hold_cnt_d;
      press_short <= short_evt;
      press_long  <= long_evt;
    end
  end

  // A long press that turns auto mode off wins over a coinciding swap, freezing the color.
  assign swap_term = auto_mode & ~long_evt & (swap_cnt == SWAP_LAST);

  // Color, auto-mode flag and the auto-swap period counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      dsp_Hex   <= 1'b0;
      auto_mode <= 1'b0;
      swap_cnt  <= '0;
    end else begin
      if (long_evt) begin
        auto_mode <= ~auto_mode;
      end
      // Short press and terminal count together give a single toggle.
      if (short_evt | swap_term) begin
        dsp_Hex <= ~dsp_Hex;
      end
      if (!auto_mode || long_evt || short_evt || (swap_cnt == SWAP_LAST)) begin
        swap_cnt <= '0;
      end else begin
        swap_cnt <= swap_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_led_color_sel.sv
// Bench for led_color_sel: directed vector table, hand-written multi-cycle corner
// cases, and random button/reset activity compared against an event-level model.
module tb_led_color_sel;

  localparam int unsigned DEB = 4;
  localparam int unsigned LNG = 20;
  localparam int unsigned SWP = 10;

  logic clk = 1'b0;
  logic rst;
  logic btn_n;
  logic dsp_Hex;
  logic auto_mode;
  logic press_short;
  logic press_long;

  int checks   = 0;
  int failures = 0;

  led_color_sel #(
    .IN_HZ       (1000),
    .DEBOUNCE_CYC(DEB),
    .LONG_CYC    (LNG),
    .SWAP_CYC    (SWP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .dsp_Hex    (dsp_Hex),
    .auto_mode  (auto_mode),
    .press_short(press_short),
    .press_long (press_long)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (edge-indexed, event level) ----------------
  bit          chk_en = 1'b0;
  bit          m_sync[$];
  bit          m_win[$];
  bit          m_db, m_in_press, m_long_done, m_auto, m_dsp, m_short, m_long;
  int unsigned m_n = 0;
  int unsigned m_start = 0;
  int unsigned m_next_swap = 0;

  task automatic model_step();
    bit sp, all_diff, accept, short_e, long_e, term;
    m_n++;
    if (rst === 1'b1) begin
      m_sync = {1'b1, 1'b1};
      m_win = {};
      m_db = 0; m_in_press = 0; m_long_done = 0;
      m_auto = 0; m_dsp = 0; m_short = 0; m_long = 0;
      return;
    end
    // Raw button reaches the debouncer two edges late.
    sp = !m_sync[0];
    void'(m_sync.pop_front());
    m_sync.push_back(btn_n);
    // Accept a new level once the last DEB samples all disagree with the current one.
    m_win.push_back(sp);
    if (m_win.size() > DEB) void'(m_win.pop_front());
    all_diff = (m_win.size() == DEB);
    foreach (m_win[k]) if (m_win[k] == m_db) all_diff = 0;
    accept = all_diff;
    short_e = 0;
    long_e  = 0;
    if (accept) m_db = sp;
    if (accept && sp) begin
      m_in_press = 1; m_long_done = 0; m_start = m_n;
    end else if (accept && !sp) begin
      if (m_in_press && !m_long_done) short_e = 1;
      m_in_press = 0;
    end else if (m_in_press && !m_long_done && (m_n - m_start == LNG)) begin
      long_e = 1; m_long_done = 1;
    end
    term = m_auto && (m_n == m_next_swap) && !long_e;
    if (short_e || term) m_next_swap = m_n + SWP;
    if (short_e || term) m_dsp = !m_dsp;
    if (long_e) begin
      m_auto = !m_auto;
      if (m_auto) m_next_swap = m_n + SWP;
    end
    m_short = short_e;
    m_long  = long_e;
  endtask

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_dsp_Hex", dsp_Hex, m_dsp);
      check("mdl_auto_mode", auto_mode, m_auto);
      check("mdl_press_short", press_short, m_short);
      check("mdl_press_long", press_long, m_long);
    end
  end

  // ---------------- directed helpers ----------------
  int r_short_n, r_short_at, r_long_n, r_long_at;
  bit dsp_tr[0:127];
  bit auto_tr[0:127];

  task automatic do_reset();
    rst = 1'b1;
    btn_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Button held low before edges 1..low, released afterwards; outputs traced per edge.
  task automatic run_press(input int low, input int total, input int rst_at);
    r_short_n = 0; r_short_at = 0; r_long_n = 0; r_long_at = 0;
    for (int i = 1; i <= total; i++) begin
      btn_n = (i <= low) ? 1'b0 : 1'b1;
      rst   = (i == rst_at) ? 1'b1 : 1'b0;
      @(negedge clk);
      if (press_short === 1'b1) begin
        r_short_n++;
        if (r_short_at == 0) r_short_at = i;
      end
      if (press_long === 1'b1) begin
        r_long_n++;
        if (r_long_at == 0) r_long_at = i;
      end
      dsp_tr[i]  = dsp_Hex;
      auto_tr[i] = auto_mode;
    end
    rst = 1'b0;
  endtask

  typedef struct {
    string name;
    int    low;
    int    total;
    int    short_n;
    int    short_at;
    int    long_n;
    int    long_at;
    bit    dsp;
    bit    auto_on;
  } vec_t;

  vec_t vecs[6];

  task automatic set_vec(input int idx, input string name, input int low, input int total,
                         input int sn, input int sa, input int ln, input int la,
                         input bit dsp, input bit auto_on);
    vecs[idx].name = name; vecs[idx].low = low; vecs[idx].total = total;
    vecs[idx].short_n = sn; vecs[idx].short_at = sa;
    vecs[idx].long_n = ln; vecs[idx].long_at = la;
    vecs[idx].dsp = dsp; vecs[idx].auto_on = auto_on;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int remaining;
    // Level rises on edge 2+DEB=6; release accepted on edge low+6; long on edge 26.
    set_vec(0, "glitch3", 3, 20, 0, 0, 0, 0, 1'b0, 1'b0);
    set_vec(1, "short10", 10, 25, 1, 16, 0, 0, 1'b1, 1'b0);
    set_vec(2, "short4_min", 4, 20, 1, 10, 0, 0, 1'b1, 1'b0);
    set_vec(3, "short19_edge", 19, 35, 1, 25, 0, 0, 1'b1, 1'b0);
    set_vec(4, "long21_edge", 21, 40, 0, 0, 1, 26, 1'b1, 1'b1);
    set_vec(5, "long40", 40, 50, 0, 0, 1, 26, 1'b0, 1'b1);

    rst = 1'b1;
    btn_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    check("reset_dsp_Hex", dsp_Hex, 0);
    check("reset_auto_mode", auto_mode, 0);
    check("reset_press_short", press_short, 0);
    check("reset_press_long", press_long, 0);
    rst = 1'b0;

    foreach (vecs[v]) begin
      do_reset();
      run_press(vecs[v].low, vecs[v].total, 0);
      check({vecs[v].name, "_short_n"}, r_short_n, vecs[v].short_n);
      check({vecs[v].name, "_short_at"}, r_short_at, vecs[v].short_at);
      check({vecs[v].name, "_long_n"}, r_long_n, vecs[v].long_n);
      check({vecs[v].name, "_long_at"}, r_long_at, vecs[v].long_at);
      check({vecs[v].name, "_dsp"}, dsp_tr[vecs[v].total], vecs[v].dsp);
      check({vecs[v].name, "_auto"}, auto_tr[vecs[v].total], vecs[v].auto_on);
    end

    // Auto alternation: enabled on edge 26, toggles on 36, 46, ...
    do_reset();
    run_press(40, 50, 0);
    for (int i = 26; i <= 50; i++) begin
      check("auto_period_dsp", dsp_tr[i], ((i - 26) / 10) % 2);
      check("auto_period_mode", auto_tr[i], 1);
    end
    // Continue: short press lands on the terminal count at global edge 66 (local 16).
    run_press(10, 30, 0);
    check("coinc_short_n", r_short_n, 1);
    check("coinc_short_at", r_short_at, 16);
    check("coinc_long_n", r_long_n, 0);
    check("coinc_dsp_before", dsp_tr[15], 1);
    check("coinc_dsp_after", dsp_tr[16], 0);
    check("coinc_dsp_hold", dsp_tr[25], 0);
    check("coinc_dsp_next", dsp_tr[26], 1);

    // Reset in HELD at hold count 10 (edge 17), button released right after.
    do_reset();
    run_press(17, 40, 17);
    check("rst_held_dsp", dsp_tr[17], 0);
    check("rst_held_auto", auto_tr[17], 0);
    check("rst_held_short_n", r_short_n, 0);
    check("rst_held_long_n", r_long_n, 0);
    check("rst_held_dsp_end", dsp_tr[40], 0);

    // Reset mid-press with button still held: re-debounced (rise 18), release at 36.
    do_reset();
    run_press(30, 45, 12);
    check("rst_redeb_short_n", r_short_n, 1);
    check("rst_redeb_short_at", r_short_at, 36);
    check("rst_redeb_long_n", r_long_n, 0);
    check("rst_redeb_dsp", dsp_tr[45], 1);

    // Random button runs with occasional reset, checked every edge against the model.
    do_reset();
    remaining = 0;
    for (int c = 0; c < 4000; c++) begin
      if (remaining == 0) begin
        btn_n = ~btn_n;
        remaining = $urandom_range(1, 35);
      end
      remaining--;
      rst = ($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    rst = 1'b0;
    btn_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_color_sel.md
LED_COLOR_SEL -- requirements
Module: led_color_sel

Interface
- REQ-001: The block SHALL have parameter IN_HZ, default 50_000_000, meaning the clock frequency in Hz.
- REQ-002: The block SHALL have parameter DEBOUNCE_CYC, default IN_HZ/100, meaning the stable cycles required to accept a button level.
- REQ-003: The block SHALL have parameter LONG_CYC, default IN_HZ, meaning the debounced hold cycles that qualify a long press.
- REQ-004: The block SHALL have parameter SWAP_CYC, default IN_HZ*5, meaning the auto-mode color period in cycles.
- REQ-005: The block SHALL have one clock and a synchronous, active-high reset.
- REQ-006: The block SHALL have port clk, input, 1 bit: the system clock, with all logic on its rising edge.
- REQ-007: The block SHALL have port rst, input, 1 bit: the synchronous active-high reset.
- REQ-008: The block SHALL have port btn_n, input, 1 bit: the raw asynchronous push-button, active-low (0 = pressed).
- REQ-009: The block SHALL have port dsp_Hex, output, 1 bit: the color select to the downstream PWM stage (1 = red, 0 = green).
- REQ-010: The block SHALL have port auto_mode, output, 1 bit: 1 while automatic alternation is enabled.
- REQ-011: The block SHALL have port press_short, output, 1 bit: a 1-cycle pulse when a short press is accepted.
- REQ-012: The block SHALL have port press_long, output, 1 bit: a 1-cycle pulse when a long press is accepted.

Function
- REQ-013: The block SHALL pass btn_n through a 2-flop synchronizer, producing sync_pressed = ~(second-stage value).
- REQ-014: The block SHALL update the debounced level btn_db to sync_pressed only after sync_pressed differs from btn_db for DEBOUNCE_CYC consecutive cycles.
- REQ-015: Any cycle where sync_pressed equals btn_db SHALL clear the debounce counter, and glitches shorter than DEBOUNCE_CYC cycles SHALL produce no change.
- REQ-016: The block SHALL implement a press FSM with states IDLE, HELD and LONG.
- REQ-017: IDLE SHALL move to HELD when btn_db rises, clearing the hold counter.
- REQ-018: In HELD the hold counter SHALL increment each cycle; on the cycle it equals LONG_CYC-1 the FSM SHALL move to LONG, pulse press_long and toggle auto_mode on that same edge.
- REQ-019: HELD SHALL move to IDLE when btn_db falls, pulsing press_short and toggling dsp_Hex on that same edge.
- REQ-020: LONG SHALL move to IDLE when btn_db falls, with no press_short pulse and no dsp_Hex toggle.
- REQ-021: The hold counter SHALL saturate and SHALL NOT wrap while in LONG.
- REQ-022: The swap counter, 32 bits wide, SHALL increment each cycle while auto_mode=1 and be held at 0 while auto_mode=0.
- REQ-023: When the swap counter equals SWAP_CYC-1, dsp_Hex SHALL toggle and the counter SHALL return to 0.
- REQ-024: A short press SHALL clear the swap counter, so the next auto toggle occurs SWAP_CYC cycles later.
- REQ-025: When a short press and a swap terminal count coincide, dsp_Hex SHALL toggle exactly once and the swap counter SHALL clear.
- REQ-026: A long press that enables auto_mode SHALL start the swap counter from 0, and one that disables it SHALL freeze dsp_Hex at its current value.
- REQ-027: All counters SHALL be unsigned, sized to hold their parameter value, and all compares SHALL be exact equality.

Reset
- REQ-028: On rst=1 at a clock edge, all registers SHALL clear: dsp_Hex=0, auto_mode=0, press_short=0, press_long=0, FSM=IDLE, btn_db=0 (released), synchronizer=released, and all counters=0.
- REQ-029: Reset asserted mid-press SHALL abort the press with no pulses; a button still held after reset SHALL be re-debounced as a new press.
- REQ-030: Reset SHALL take priority over every other event in the same cycle.

Verification (bench parameters DEBOUNCE_CYC=4, LONG_CYC=20, SWAP_CYC=10)
- REQ-031: The bench SHALL cover this case: 3-cycle low glitch on btn_n → btn_db unchanged, no pulses, dsp_Hex stays 0.
- REQ-032: The bench SHALL cover this case: hold btn_n low for 10 cycles, then release → one press_short pulse after release is debounced, and dsp_Hex 0→1.
- REQ-033: The bench SHALL cover this case: hold btn_n low for 40 cycles → press_long pulses exactly once, 20 cycles after btn_db rises; auto_mode=1; no press_short on release.
- REQ-034: The bench SHALL cover this case: auto_mode=1 with no button activity → dsp_Hex toggles every 10 cycles (period 20), starting 10 cycles after the auto_mode edge.
- REQ-035: The bench SHALL cover this case: short press released so press_short coincides with swap count 9 → a single dsp_Hex toggle, then the next toggle 10 cycles later.
- REQ-036: The bench SHALL cover this case: rst pulsed during HELD at hold count 10 → all outputs 0, FSM IDLE, and no press_short when the button is released.
